// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pic_pkg
//  Purpose  : Shared types, constants and bit helpers for the 8259 PIC blocks
//  Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2,
        ST_ACK3 = 2'd3
    } inta_state_t;

    localparam logic [7:0] CALL_OPCODE    = 8'hCD;
    localparam logic [7:0] SPURIOUS_LEVEL = 8'h80;

    function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] w_wide;
        w_wide = {value, value} >> amount;
        return w_wide[7:0];
    endfunction

    function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] w_wide;
        w_wide = {value, value} << amount;
        return w_wide[15:8];
    endfunction

    function automatic logic [7:0] isolate_lowest(input logic [7:0] value);
        return value & (~value + 8'd1);
    endfunction

    function automatic logic [2:0] onehot_to_index(input logic [7:0] value);
        logic [2:0] w_index;
        w_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (value[i]) w_index = i[2:0];
        end
        return w_index;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_priority_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : pic_priority_resolver
//  Purpose  : Picks the highest-priority unmasked request and checks it
//             against the level currently in service (rotating priority)
//  Revision : 1.0 - initial release
// ============================================================================
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] candidates,
    input  logic [7:0] in_service,
    input  logic [2:0] priority_rotate,
    output logic [7:0] winner,
    output logic       valid
);

    logic [2:0] w_shift;
    logic [7:0] w_cand_rot;
    logic [7:0] w_cand_low;
    logic [7:0] w_isr_rot;
    logic [7:0] w_isr_low;
    logic [7:0] w_higher_mask;

    // After rotating by rotate+1, bit 0 is the highest-priority level.
    assign w_shift    = priority_rotate + 3'd1;
    assign w_cand_rot = rotate_right(candidates, w_shift);
    assign w_cand_low = isolate_lowest(w_cand_rot);
    assign w_isr_rot  = rotate_right(in_service, w_shift);
    assign w_isr_low  = isolate_lowest(w_isr_rot);

    // Bits strictly below the in-service bit are the levels allowed to nest.
    assign w_higher_mask = (w_isr_low == 8'h00) ? 8'hFF : (w_isr_low - 8'd1);

    assign valid  = |(w_cand_low & w_higher_mask);
    assign winner = valid ? rotate_left(w_cand_low, w_shift) : 8'h00;

endmodule
`default_nettype wire

// File: rtl/pic_inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pic_inta_sequencer
//  Purpose  : IRR capture, priority resolution, INT generation and the
//             8086 / MCS-80 INTA pulse sequence with vector byte output
//  Revision : 1.0 - initial release
// ============================================================================
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  interrupt_request_pin,
    input  logic        inta_n,
    input  logic        level_or_edge_triggered_config,
    input  logic        u8086_or_mcs80_config,
    input  logic        auto_eoi_config,
    input  logic [7:0]  interrupt_mask,
    input  logic [2:0]  priority_rotate,
    input  logic [7:0]  highest_level_in_service,
    input  logic [10:0] interrupt_vector_address,
    output logic        interrupt_to_cpu,
    output logic [7:0]  interrupt,
    output logic        latch_in_service,
    output logic [7:0]  end_of_interrupt,
    output logic [7:0]  interrupt_request_register,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_out_enable
);

    logic [SYNC_STAGES-1:0][7:0] r_irq_sync;
    logic [SYNC_STAGES-1:0]      r_inta_sync;
    logic                        r_inta_d;
    logic [7:0]                  r_irq_prev;
    logic [7:0]                  r_irr;
    inta_state_t                 r_state;
    logic                        r_int;
    logic [7:0]                  r_interrupt;
    logic                        r_latch;
    logic [7:0]                  r_eoi;
    logic                        r_real_ack;
    logic                        r_mode_8086;

    logic [7:0] w_irq_s;
    logic       w_inta_s;
    logic       w_inta_fall;
    logic       w_inta_rise;
    logic       w_freeze;
    logic [7:0] w_winner;
    logic       w_valid;
    logic [7:0] w_ack_clear;
    logic [7:0] w_irr_next;
    logic [2:0] w_lvl;
    logic [7:0] w_dbo;
    logic       w_dbo_en;

    assign w_irq_s     = r_irq_sync[SYNC_STAGES-1];
    assign w_inta_s    = r_inta_sync[SYNC_STAGES-1];
    assign w_inta_fall = r_inta_d & ~w_inta_s;
    assign w_inta_rise = ~r_inta_d & w_inta_s;
    assign w_freeze    = (r_state == ST_IDLE) && w_inta_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_sync  <= '0;
            r_inta_sync <= '1;
            r_inta_d    <= 1'b1;
            r_irq_prev  <= 8'h00;
        end else begin
            r_irq_sync  <= {r_irq_sync[SYNC_STAGES-2:0], interrupt_request_pin};
            r_inta_sync <= {r_inta_sync[SYNC_STAGES-2:0], inta_n};
            r_inta_d    <= w_inta_s;
            r_irq_prev  <= w_irq_s;
        end
    end

    pic_priority_resolver u_resolver (
        .candidates      (r_irr & ~interrupt_mask),
        .in_service      (highest_level_in_service),
        .priority_rotate (priority_rotate),
        .winner          (w_winner),
        .valid           (w_valid)
    );

    // Acknowledge clear wins over a simultaneous set.
    assign w_ack_clear = w_freeze ? w_winner : 8'h00;
    assign w_irr_next  = level_or_edge_triggered_config ? w_irq_s
                       : ((r_irr | (w_irq_s & ~r_irq_prev)) & w_irq_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irr <= 8'h00;
        end else begin
            r_irr <= w_irr_next & ~w_ack_clear;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_int       <= 1'b0;
            r_interrupt <= 8'h00;
            r_latch     <= 1'b0;
            r_eoi       <= 8'h00;
            r_real_ack  <= 1'b0;
            r_mode_8086 <= 1'b0;
        end else begin
            r_int   <= 1'b0;
            r_latch <= 1'b0;
            r_eoi   <= 8'h00;
            case (r_state)
                ST_IDLE: begin
                    r_int <= w_valid & ~w_inta_fall;
                    if (w_inta_fall) begin
                        r_interrupt <= w_valid ? w_winner : SPURIOUS_LEVEL;
                        r_latch     <= w_valid;
                        r_real_ack  <= w_valid;
                        r_mode_8086 <= u8086_or_mcs80_config;
                        r_state     <= ST_ACK1;
                    end
                end
                ST_ACK1: begin
                    if (w_inta_fall) r_state <= ST_ACK2;
                end
                ST_ACK2: begin
                    if (r_mode_8086 && w_inta_rise) begin
                        r_state <= ST_IDLE;
                        if (auto_eoi_config && r_real_ack) r_eoi <= r_interrupt;
                    end else if (!r_mode_8086 && w_inta_fall) begin
                        r_state <= ST_ACK3;
                    end
                end
                ST_ACK3: begin
                    if (w_inta_rise) begin
                        r_state <= ST_IDLE;
                        if (auto_eoi_config && r_real_ack) r_eoi <= r_interrupt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_lvl = onehot_to_index(r_interrupt);

    always_comb begin
        w_dbo    = 8'h00;
        w_dbo_en = 1'b0;
        if (!w_inta_s) begin
            case (r_state)
                ST_ACK1: begin
                    if (!r_mode_8086) begin
                        w_dbo_en = 1'b1;
                        w_dbo    = CALL_OPCODE;
                    end
                end
                ST_ACK2: begin
                    w_dbo_en = 1'b1;
                    w_dbo    = r_mode_8086 ? {interrupt_vector_address[10:6], w_lvl}
                                           : {interrupt_vector_address[2:0], w_lvl, 2'b00};
                end
                ST_ACK3: begin
                    if (!r_mode_8086) begin
                        w_dbo_en = 1'b1;
                        w_dbo    = interrupt_vector_address[10:3];
                    end
                end
                default: begin
                    w_dbo    = 8'h00;
                    w_dbo_en = 1'b0;
                end
            endcase
        end
    end

    assign interrupt_to_cpu           = r_int;
    assign interrupt                  = r_interrupt;
    assign latch_in_service           = r_latch;
    assign end_of_interrupt           = r_eoi;
    assign interrupt_request_register = r_irr;
    assign data_bus_out               = w_dbo;
    assign data_bus_out_enable        = w_dbo_en;

endmodule
`default_nettype wire

// File: tb/tb_pic_inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pic_inta_sequencer
//  Purpose  : Directed, table-driven self-checking bench for the INTA sequencer
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pic_inta_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq;
    logic        inta_n;
    logic        level_cfg;
    logic        mode_8086;
    logic        auto_eoi;
    logic [7:0]  mask;
    logic [2:0]  rot;
    logic [7:0]  isr;
    logic [10:0] vec_addr;
    logic        int_cpu;
    logic [7:0]  intr;
    logic        latch;
    logic [7:0]  eoi;
    logic [7:0]  irr;
    logic [7:0]  dbo;
    logic        dbo_en;

    int n_checks = 0;
    int n_fail   = 0;

    pic_inta_sequencer #(.SYNC_STAGES(2)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .interrupt_request_pin          (irq),
        .inta_n                         (inta_n),
        .level_or_edge_triggered_config (level_cfg),
        .u8086_or_mcs80_config          (mode_8086),
        .auto_eoi_config                (auto_eoi),
        .interrupt_mask                 (mask),
        .priority_rotate                (rot),
        .highest_level_in_service       (isr),
        .interrupt_vector_address       (vec_addr),
        .interrupt_to_cpu               (int_cpu),
        .interrupt                      (intr),
        .latch_in_service               (latch),
        .end_of_interrupt               (eoi),
        .interrupt_request_register     (irr),
        .data_bus_out                   (dbo),
        .data_bus_out_enable            (dbo_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq;
        logic [7:0] mask;
        logic [2:0] rot;
        logic [7:0] isr;
        logic       exp_int;
        logic [7:0] exp_win;
        logic [7:0] exp_vec;
    } vec_t;

    vec_t tbl [7];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fall();
        inta_n = 1'b0;
        step(3);
    endtask

    task automatic rise();
        inta_n = 1'b1;
        step(3);
    endtask

    task automatic run_ack(input logic is_8086, input logic [7:0] exp_intr, input logic exp_lat,
                           input logic [7:0] exp_b2, input logic [7:0] exp_b3, input logic [7:0] exp_eoi);
        fall();
        check("freeze_interrupt", intr, exp_intr);
        check("latch_in_service", latch, exp_lat);
        check("irr_ack_cleared", irr & exp_intr, 8'h00);
        if (is_8086) check("ack1_bus_idle", dbo_en, 1'b0);
        else         check("ack1_call_byte", {dbo_en, dbo}, {1'b1, 8'hCD});
        step(1);
        check("latch_one_cycle", latch, 1'b0);
        rise();
        fall();
        check("ack2_byte", {dbo_en, dbo}, {1'b1, exp_b2});
        if (!is_8086) begin
            rise();
            check("ack2_gap_released", dbo_en, 1'b0);
            fall();
            check("ack3_byte", {dbo_en, dbo}, {1'b1, exp_b3});
        end
        rise();
        check("end_of_interrupt", eoi, exp_eoi);
        check("bus_released", {dbo_en, dbo}, 9'h000);
        step(1);
        check("eoi_one_cycle", eoi, 8'h00);
    endtask

    initial begin
        // irq,   mask,  rot,  isr,   int,  winner, 8086 vector (T=01000)
        tbl[0] = '{8'h08, 8'h00, 3'd7, 8'h00, 1'b1, 8'h08, 8'h43};
        tbl[1] = '{8'h24, 8'h00, 3'd7, 8'h00, 1'b1, 8'h04, 8'h42};
        tbl[2] = '{8'h24, 8'h00, 3'd2, 8'h00, 1'b1, 8'h20, 8'h45};
        tbl[3] = '{8'h40, 8'h00, 3'd7, 8'h04, 1'b0, 8'h00, 8'h00};
        tbl[4] = '{8'h0C, 8'h08, 3'd7, 8'h00, 1'b1, 8'h04, 8'h42};
        tbl[5] = '{8'h09, 8'h00, 3'd3, 8'h00, 1'b1, 8'h01, 8'h40};
        tbl[6] = '{8'h01, 8'h00, 3'd7, 8'h01, 1'b0, 8'h00, 8'h00};

        rst_n     = 1'b0;
        irq       = 8'h00;
        inta_n    = 1'b1;
        level_cfg = 1'b0;
        mode_8086 = 1'b1;
        auto_eoi  = 1'b0;
        mask      = 8'h00;
        rot       = 3'd7;
        isr       = 8'h00;
        vec_addr  = {5'b01000, 6'b000000};
        step(3);
        check("reset_int", int_cpu, 1'b0);
        check("reset_interrupt", intr, 8'h00);
        check("reset_irr", irr, 8'h00);
        check("reset_pulses", {latch, eoi}, 9'h000);
        check("reset_bus", {dbo_en, dbo}, 9'h000);
        rst_n = 1'b1;
        step(2);

        for (int i = 0; i < 7; i++) begin
            mask = tbl[i].mask;
            rot  = tbl[i].rot;
            isr  = tbl[i].isr;
            irq  = tbl[i].irq;
            step(4);
            check($sformatf("vec%0d_int", i), int_cpu, tbl[i].exp_int);
            if (tbl[i].exp_int)
                run_ack(1'b1, tbl[i].exp_win, 1'b1, tbl[i].exp_vec, 8'h00, 8'h00);
            irq = 8'h00;
            step(4);
            check($sformatf("vec%0d_irr_idle", i), irr, 8'h00);
        end
        mask = 8'h00;
        rot  = 3'd7;
        isr  = 8'h00;

        // Nested request: IR6 blocked by IR2 in service, IR1 may interrupt it
        isr = 8'h04;
        irq = 8'h40;
        step(6);
        check("nest_blocked_int", int_cpu, 1'b0);
        irq = 8'h42;
        step(4);
        check("nest_allowed_int", int_cpu, 1'b1);
        run_ack(1'b1, 8'h02, 1'b1, 8'h41, 8'h00, 8'h00);
        irq = 8'h00;
        isr = 8'h00;
        step(4);

        // Level mode follows the synchronised pin
        level_cfg = 1'b1;
        irq = 8'h40;
        step(3);
        check("level_irr_set", irr, 8'h40);
        irq = 8'h00;
        step(3);
        check("level_irr_clear", irr, 8'h00);
        level_cfg = 1'b0;
        step(2);

        // MCS-80 three-pulse sequence with auto EOI
        mode_8086 = 1'b0;
        auto_eoi  = 1'b1;
        vec_addr  = 11'b10100000_011;
        irq = 8'h02;
        step(4);
        check("mcs80_int", int_cpu, 1'b1);
        run_ack(1'b0, 8'h02, 1'b1, 8'h64, 8'hA0, 8'h02);
        irq = 8'h00;
        step(4);

        // Request withdrawn before INTA gives a spurious IR7 acknowledge
        mode_8086 = 1'b1;
        vec_addr  = {5'b01000, 6'b000000};
        irq = 8'h10;
        step(4);
        check("spur_int_raised", int_cpu, 1'b1);
        irq = 8'h00;
        step(4);
        check("spur_int_dropped", int_cpu, 1'b0);
        run_ack(1'b1, 8'h80, 1'b0, 8'h47, 8'h00, 8'h00);
        step(2);

        // Reset asserted in ACK2 aborts the sequence
        irq = 8'h01;
        step(4);
        fall();
        rise();
        fall();
        check("pre_reset_ack2_byte", {dbo_en, dbo}, {1'b1, 8'h40});
        rst_n = 1'b0;
        #1;
        check("async_reset_interrupt", intr, 8'h00);
        check("async_reset_irr", irr, 8'h00);
        check("async_reset_bus", {dbo_en, dbo}, 9'h000);
        check("async_reset_int_eoi", {int_cpu, eoi}, 9'h000);
        inta_n = 1'b1;
        irq    = 8'h00;
        step(3);
        check("reset_held_no_eoi", eoi, 8'h00);
        rst_n = 1'b1;
        step(2);
        irq = 8'h01;
        step(4);
        check("post_reset_int", int_cpu, 1'b1);
        run_ack(1'b1, 8'h01, 1'b1, 8'h40, 8'h00, 8'h01);
        irq = 8'h00;
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
